axi_mem_slave_burst: RTL and testbench
======================================

// Module: axi_mem_slave_burst
// PURPOSE: AXI4 INCR-burst memory slave sitting directly downstream of the passthrough VIP in ex_sim; it terminates the
//   master VIP's traffic in a real word array so that the passthrough VIP can run in passive/monitor mode against real RTL.
// PARAMETERS
//   ADDR_WIDTH  32    byte address width of awaddr/araddr
//   DATA_WIDTH  32    data bus width in bits (32 or 64); wstrb = DATA_WIDTH/8
//   ID_WIDTH    4     transaction ID width, echoed on bid/rid
//   MEM_WORDS   1024  memory depth in DATA_WIDTH words (power of 2); base address 0
// PORTS
//   aclk     in   1             clock, all logic on rising edge
//   areset   in   1             synchronous active-high reset
//   awid     in   ID_WIDTH      write ID
//   awaddr   in   ADDR_WIDTH    write start byte address
//   awlen    in   8             write beats-1
//   awvalid  in   1             write address valid
//   awready  out  1             write address ready
//   wdata    in   DATA_WIDTH    write data
//   wstrb    in   DATA_WIDTH/8  byte enables
//   wlast    in   1             last write beat
//   wvalid   in   1             write data valid
//   wready   out  1             write data ready
//   bid      out  ID_WIDTH      response ID (= captured awid)
//   bresp    out  2             OKAY=00, SLVERR=10, DECERR=11
//   bvalid   out  1             write response valid
//   bready   in   1             write response ready
//   arid     in   ID_WIDTH      read ID
//   araddr   in   ADDR_WIDTH    read start byte address
//   arlen    in   8             read beats-1
//   arvalid  in   1             read address valid
//   arready  out  1             read address ready
//   rid      out  ID_WIDTH      read ID (= captured arid)
//   rdata    out  DATA_WIDTH    read data
//   rresp    out  2             read response
//   rlast    out  1             last read beat
//   rvalid   out  1             read data valid
//   rready   in   1             read data ready
// BEHAVIOUR
// - Reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=00, bid=rid=0, rdata=0; FSMs idle. Memory contents NOT reset.
//   areset mid-burst aborts both FSMs immediately; partially written beats stay in memory; no B/R response is issued for the aborted burst.
// - Burst type: INCR only (awburst/arburst not connected). awsize/arsize = full bus width. Word index = addr[...:log2(DATA_WIDTH/8)], +1 per beat; no 4KB check.
// - Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. W_IDLE: awready=1; an AW handshake captures id/addr/len, goes to W_DATA with awready=0, wready=1 next cycle.
//   W_DATA: each W handshake writes the bytes enabled by wstrb, count++; the beat with count==len moves to W_RESP (wready=0, bvalid=1 next cycle).
//   wlast mismatch (asserted early or missing on beat len) -> SLVERR, remaining beats are still accepted up to len.
//   W_RESP: hold bvalid/bid/bresp until bready; the cycle after the handshake: W_IDLE, awready=1. One outstanding write.
// - Read FSM R_IDLE->R_DATA->R_IDLE, independent of the write FSM. An AR handshake captures the request; arready=0; first rvalid exactly 2 cycles after the AR handshake (registered RAM).
//   R_DATA: rdata/rresp/rlast held stable while rvalid && !rready; the next beat is presented the cycle after each handshake (1 beat/clk at rready=1), rlast on beat arlen.
//   After the last handshake: rvalid=0, arready=1 next cycle.
// - Decode: a beat whose word index >= MEM_WORDS gets DECERR; writes to it are dropped, reads return 0. Burst bresp = worst beat (DECERR>SLVERR>OKAY). rresp is per beat.
// - Same-cycle write and read to the same word: read returns old data (read-first). AW and AR accepted in the same cycle are both legal.
// - awlen=255 -> 256 beats; the counter is 8 bit and must not wrap before beat 256.
// TESTING
// 1. Reset, AW addr=0x10 len=3 + 4 W beats 0xA0..0xA3 strb=F, bready=1 -> bresp=00, bid=awid; AR 0x10 len=3 -> rdata A0..A3, rlast on beat 4.
// 2. Write 0xFFFFFFFF to 0x0, then strb=0x2 data 0x00001200 -> read 0x0 = 0xFFFF12FF.
// 3. rready toggling 1/0 each cycle during an arlen=7 read -> data stable while stalled, 8 beats in order, no beat dropped.
// 4. AW addr=(MEM_WORDS-1)*4 len=1 -> bresp=11; word MEM_WORDS-1 written, no alias to word 0; read the same range -> rresp 00 then 11, rdata 0.
// 5. wlast on beat 2 of len=3 -> all 4 beats accepted, bresp=10; awlen=255 burst completes with 256 beats, one B.
// 6. areset pulse during beat 2 of a len=7 read -> rvalid=0, arready=1 the next cycle; a new read completes normally.

Source files
------------

// File: rtl/axi_mem_slave_burst_if.sv
// AXI4 write/read channel bundle between a burst master and axi_mem_slave_burst.
// Burst type, size, cache and prot are not carried because the slave only supports full-width INCR bursts.
interface axi_mem_slave_burst_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_mem_slave_burst.sv
// AXI4 INCR-burst memory slave: one outstanding write and one outstanding read, each run by its own FSM,
// sharing a word array. Beats past MEM_WORDS answer DECERR; memory contents survive reset.
module axi_mem_slave_burst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 1024
) (
  input logic                 aclk,
  input logic                 areset,
  axi_mem_slave_burst_if.slave s
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  // One spare bit so start+255 never wraps back into the valid range.
  localparam int IDX_W  = ADDR_WIDTH - OFFS + 1;
  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam logic [IDX_W-1:0] IDX_LIM = IDX_W'(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic [1:0]          r_wstate;
  logic                r_awready, r_wready, r_bvalid;
  logic [ID_WIDTH-1:0] r_bid;
  logic [1:0]          r_bresp, r_wworst;
  logic [IDX_W-1:0]    r_wbase;
  logic [7:0]          r_wlen, r_wcnt;
  logic [IDX_W-1:0]    w_widx;
  logic                w_wbeat, w_wlast_exp, w_wdec;
  logic [1:0]          w_wbeat_resp, w_wacc;

  logic [1:0]            r_rstate;
  logic                  r_arready, r_rvalid, r_rlast;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [IDX_W-1:0]      r_ridx;
  logic [7:0]            r_rlen, r_rcnt;
  logic [IDX_W-1:0]      w_rfetch_idx;
  logic [7:0]            w_rfetch_cnt;
  logic                  w_rdec;
  logic [DATA_WIDTH-1:0] w_rfetch_data;
  logic                  w_unused;

  assign w_unused = ^{s.awaddr[OFFS-1:0], s.araddr[OFFS-1:0]};

  assign w_widx      = r_wbase + IDX_W'(r_wcnt);
  assign w_wbeat     = (r_wstate == W_DATA) && r_wready && s.wvalid;
  assign w_wlast_exp = (r_wcnt == r_wlen);
  assign w_wdec      = (w_widx >= IDX_LIM);

  // Response encodings are ordered by severity, so the burst result is a running max.
  always_comb begin
    w_wbeat_resp = RESP_OKAY;
    if (w_wdec)
      w_wbeat_resp = RESP_DECERR;
    else if (s.wlast != w_wlast_exp)
      w_wbeat_resp = RESP_SLVERR;
    w_wacc = (w_wbeat_resp > r_wworst) ? w_wbeat_resp : r_wworst;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_wworst  <= RESP_OKAY;
      r_wbase   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (s.awvalid) begin
          r_wbase   <= {1'b0, s.awaddr[ADDR_WIDTH-1:OFFS]};
          r_wlen    <= s.awlen;
          r_bid     <= s.awid;
          r_wcnt    <= '0;
          r_wworst  <= RESP_OKAY;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (w_wbeat) begin
          r_wcnt   <= r_wcnt + 8'd1;
          r_wworst <= w_wacc;
          if (w_wlast_exp) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wacc;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (s.bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_wbeat && !w_wdec && !areset)
      for (int b = 0; b < STRB_W; b++)
        if (s.wstrb[b])
          r_mem[w_widx[MEM_AW-1:0]][b*8 +: 8] <= s.wdata[b*8 +: 8];
  end

  // R_WAIT fetches the first beat; in R_DATA each handshake fetches the following one.
  assign w_rfetch_idx  = (r_rstate == R_DATA) ? r_ridx + IDX_W'(1) : r_ridx;
  assign w_rfetch_cnt  = (r_rstate == R_DATA) ? r_rcnt + 8'd1 : r_rcnt;
  assign w_rdec        = (w_rfetch_idx >= IDX_LIM);
  assign w_rfetch_data = w_rdec ? '0 : r_mem[w_rfetch_idx[MEM_AW-1:0]];

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (s.arvalid) begin
          r_ridx    <= {1'b0, s.araddr[ADDR_WIDTH-1:OFFS]};
          r_rlen    <= s.arlen;
          r_rcnt    <= '0;
          r_rid     <= s.arid;
          r_arready <= 1'b0;
          r_rstate  <= R_WAIT;
        end
        R_WAIT: begin
          r_rdata  <= w_rfetch_data;
          r_rresp  <= w_rdec ? RESP_DECERR : RESP_OKAY;
          r_rlast  <= (w_rfetch_cnt == r_rlen);
          r_rvalid <= 1'b1;
          r_rstate <= R_DATA;
        end
        R_DATA: if (s.rready) begin
          if (r_rlast) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end else begin
            r_ridx  <= w_rfetch_idx;
            r_rcnt  <= w_rfetch_cnt;
            r_rdata <= w_rfetch_data;
            r_rresp <= w_rdec ? RESP_DECERR : RESP_OKAY;
            r_rlast <= (w_rfetch_cnt == r_rlen);
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s.awready = r_awready;
  assign s.wready  = r_wready;
  assign s.bvalid  = r_bvalid;
  assign s.bid     = r_bid;
  assign s.bresp   = r_bresp;
  assign s.arready = r_arready;
  assign s.rvalid  = r_rvalid;
  assign s.rid     = r_rid;
  assign s.rdata   = r_rdata;
  assign s.rresp   = r_rresp;
  assign s.rlast   = r_rlast;
endmodule

// File: tb/tb_axi_mem_slave_burst.sv
// Randomized bench for axi_mem_slave_burst: master tasks drive bursts, a word-array model predicts
// bresp, rdata and rresp from the address/strobe/wlast rules.
module tb_axi_mem_slave_burst;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MW = 1024;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi_mem_slave_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_mem_slave_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_WORDS(MW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .s      (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mdl   [MW];
  bit          known [MW];
  logic [31:0] wbuf_d [256];
  logic [3:0]  wbuf_s [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [IW-1:0] id, input logic [31:0] addr, input int len, input int early_last);
    logic [1:0] exp_resp;
    logic [1:0] beat_resp;
    int n;
    int idx;
    bit lst;
    exp_resp = 2'b00;
    for (int i = 0; i <= len; i++) begin
      idx = int'(addr >> 2) + i;
      lst = (early_last >= 0) ? (i == early_last) : (i == len);
      beat_resp = (idx >= MW) ? 2'b11 : ((lst != (i == len)) ? 2'b10 : 2'b00);
      if (beat_resp > exp_resp) exp_resp = beat_resp;
    end
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin tick(); n++; end
    if (!bus.awready) begin chk("aw_timeout", 64'd0, 64'd1); bus.awvalid = 1'b0; return; end
    tick();
    bus.awvalid = 1'b0;
    chk("aw_busy", {bus.awready, bus.wready}, 64'b01);
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin bus.wvalid = 1'b0; tick(); end
      bus.wvalid = 1'b1;
      bus.wdata  = wbuf_d[i];
      bus.wstrb  = wbuf_s[i];
      bus.wlast  = (early_last >= 0) ? (i == early_last) : (i == len);
      n = 0;
      while (!bus.wready && n < 50) begin tick(); n++; end
      if (!bus.wready) begin chk("w_timeout", 64'd0, 64'd1); break; end
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin tick(); n++; end
    chk("bvalid", bus.bvalid, 64'd1);
    chk("wready_off", bus.wready, 64'd0);
    repeat ($urandom_range(0, 2)) begin tick(); chk("b_hold", bus.bvalid, 64'd1); end
    chk("bid", bus.bid, id);
    chk("bresp", bus.bresp, exp_resp);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("b_done", {bus.bvalid, bus.awready}, 64'b01);
    for (int i = 0; i <= len; i++) begin
      idx = int'(addr >> 2) + i;
      if (idx < MW) begin
        for (int b = 0; b < 4; b++)
          if (wbuf_s[i][b]) mdl[idx][b*8 +: 8] = wbuf_d[i][b*8 +: 8];
        known[idx] = known[idx] || (wbuf_s[i] == 4'hF);
      end
    end
  endtask

  // mode: 0 random rready, 1 toggling rready, 2 rready held high. abort_at >= 0 pulses reset at that beat.
  task automatic axi_read(input logic [IW-1:0] id, input logic [31:0] addr, input int len, input int mode,
                          input int abort_at);
    int n, beat, cyc, idx;
    bit rr, tog, stalled;
    logic [63:0] saved;
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin tick(); n++; end
    if (!bus.arready) begin chk("ar_timeout", 64'd0, 64'd1); bus.arvalid = 1'b0; return; end
    tick();
    bus.arvalid = 1'b0;
    chk("ar_busy", bus.arready, 64'd0);
    chk("r_lat1", bus.rvalid, 64'd0);
    tick();
    chk("r_lat2", bus.rvalid, 64'd1);
    beat = 0; cyc = 0; tog = 1'b1; stalled = 1'b0; saved = '0;
    while (beat <= len && cyc < 2000) begin
      if (beat == abort_at) break;
      case (mode)
        0:       rr = ($urandom_range(0, 2) != 0);
        1:       begin rr = tog; tog = !tog; end
        default: rr = 1'b1;
      endcase
      bus.rready = rr;
      if (bus.rvalid) begin
        if (stalled) chk("r_stable", {25'd0, bus.rdata, bus.rresp, bus.rlast, bus.rid}, saved);
        if (rr) begin
          idx = int'(addr >> 2) + beat;
          chk("rresp", bus.rresp, (idx >= MW) ? 64'd3 : 64'd0);
          chk("rlast", bus.rlast, 64'(beat == len));
          chk("rid", bus.rid, id);
          if (idx >= MW) chk("rdata_dec", bus.rdata, 64'd0);
          else if (known[idx]) chk("rdata", bus.rdata, mdl[idx]);
          beat++;
          stalled = 1'b0;
        end else begin
          saved = {25'd0, bus.rdata, bus.rresp, bus.rlast, bus.rid};
          stalled = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    bus.rready = 1'b0;
    if (abort_at >= 0) begin
      areset = 1'b1;
      tick();
      areset = 1'b0;
      chk("abort_r", {bus.rvalid, bus.arready, bus.rlast}, 64'b010);
      chk("abort_w", {bus.awready, bus.wready, bus.bvalid}, 64'b100);
    end else begin
      chk("r_beats", 64'(beat), 64'(len + 1));
      chk("r_done", {bus.rvalid, bus.arready}, 64'b01);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, el, widx;
    for (int i = 0; i < MW; i++) begin mdl[i] = '0; known[i] = 1'b0; end
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) tick();
    chk("rst_ready", {bus.awready, bus.arready, bus.wready}, 64'b110);
    chk("rst_valid", {bus.bvalid, bus.rvalid, bus.rlast}, 64'b000);
    chk("rst_resp", {bus.bresp, bus.rresp}, 64'd0);
    chk("rst_ids", {bus.bid, bus.rid}, 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    areset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin wbuf_d[i] = 32'hA0 + i; wbuf_s[i] = 4'hF; end
    axi_write(4'd5, 32'h10, 3, -1);
    axi_read(4'd3, 32'h10, 3, 2, -1);

    wbuf_d[0] = 32'hFFFF_FFFF; wbuf_s[0] = 4'hF;
    axi_write(4'd1, 32'h0, 0, -1);
    wbuf_d[0] = 32'h0000_1200; wbuf_s[0] = 4'h2;
    axi_write(4'd2, 32'h0, 0, -1);
    axi_read(4'd7, 32'h0, 0, 2, -1);

    for (int i = 0; i < 8; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    axi_write(4'd9, 32'h100, 7, -1);
    axi_read(4'd9, 32'h100, 7, 1, -1);

    for (int i = 0; i < 2; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    axi_write(4'd4, 32'((MW - 1) * 4), 1, -1);
    axi_read(4'd4, 32'((MW - 1) * 4), 1, 0, -1);
    axi_read(4'd6, 32'h0, 0, 2, -1);

    for (int i = 0; i < 4; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    axi_write(4'd8, 32'h40, 3, 1);
    axi_read(4'd8, 32'h40, 3, 0, -1);

    for (int i = 0; i < 256; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    axi_write(4'hC, 32'h400, 255, -1);
    axi_read(4'hC, 32'h400, 255, 2, -1);

    for (int i = 0; i < 8; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    axi_write(4'd2, 32'h80, 7, -1);
    axi_read(4'd2, 32'h80, 7, 2, 2);
    axi_read(4'd3, 32'h80, 7, 0, -1);

    for (int i = 0; i < 4; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    fork
      axi_write(4'hA, 32'h200, 3, -1);
      axi_read(4'hB, 32'h10, 3, 0, -1);
    join
    axi_read(4'hA, 32'h200, 3, 2, -1);

    for (int t = 0; t < 12; t++) begin
      len  = $urandom_range(0, 15);
      widx = $urandom_range(0, MW + 8);
      el   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
      for (int i = 0; i <= len; i++) begin
        wbuf_d[i] = $urandom;
        wbuf_s[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      end
      axi_write(4'($urandom_range(0, 15)), 32'(widx * 4), len, el);
      axi_read(4'($urandom_range(0, 15)), 32'(widx * 4), len, $urandom_range(0, 2), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
